// File: rtl/ef_smsdac_spi_rx.sv
// ef_smsdac_spi_rx
// SPI (mode 0) sample receiver plus rate-pacing FIFO feeding the DAC d_in.
// SPI pins are oversampled on i_clk through 2-FF synchronizers; received bytes
// are queued in a small FIFO and released one per programmable sample period.
//
// Ports
//   i_clk        system clock (shared with the DAC core)
//   i_rst_b      asynchronous active-low reset
//   i_spi_sck    SPI clock (async, mode 0)
//   i_spi_cs_b   SPI chip select, active-low (async)
//   i_spi_mosi   SPI data in, MSB first
//   o_spi_miso   status byte out, MSB first
//   i_div        sample period minus 1, in i_clk cycles (quasi-static)
//   i_clr_flags  synchronous clear of overflow/underflow/armed
//   o_d_out      current sample to the DAC
//   o_d_valid    one-cycle pulse when o_d_out takes a new sample
//   o_underflow  sticky: a tick found the FIFO empty after arming
//   o_overflow   sticky: a byte was dropped because the FIFO was full
module ef_smsdac_spi_rx #(
  parameter int FIFO_DEPTH = 4,
  parameter int DIV_W      = 8
) (
  input  logic             i_clk,
  input  logic             i_rst_b,
  input  logic             i_spi_sck,
  input  logic             i_spi_cs_b,
  input  logic             i_spi_mosi,
  output logic             o_spi_miso,
  input  logic [DIV_W-1:0] i_div,
  input  logic             i_clr_flags,
  output logic [7:0]       o_d_out,
  output logic             o_d_valid,
  output logic             o_underflow,
  output logic             o_overflow
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam logic [PTR_W:0]   PTR_ONE = 1;
  localparam logic [DIV_W-1:0] CNT_ONE = 1;

  // synchronizers; cs_b idles high so it resets to 1
  logic r_sck_m, r_sck_s, r_sck_d;
  logic r_cs_m, r_cs_s, r_cs_d;
  logic r_mosi_m, r_mosi_s;

  logic [7:0]       r_shift;
  logic [2:0]       r_bitcnt;
  logic [7:0]       r_tx;
  logic [7:0]       r_mem [FIFO_DEPTH];
  logic [PTR_W:0]   r_wptr, r_rptr;
  logic [DIV_W-1:0] r_cnt;
  logic             r_armed, r_und, r_ovf, r_dv;
  logic [7:0]       r_dout;

  logic           w_sck_rise, w_sck_fall, w_cs_fall;
  logic           w_push, w_push_ok, w_pop, w_tick, w_empty, w_full;
  logic [7:0]     w_byte, w_status;
  logic [PTR_W:0] w_level;
  logic [2:0]     w_lvl_sat;

  assign w_sck_rise = r_sck_s & ~r_sck_d;
  assign w_sck_fall = ~r_sck_s & r_sck_d;
  assign w_cs_fall  = ~r_cs_s & r_cs_d;

  assign w_push = ~r_cs_s & w_sck_rise & (r_bitcnt == 3'd7);
  assign w_byte = {r_shift[6:0], r_mosi_s};

  assign w_empty = (r_wptr == r_rptr);
  assign w_full  = (r_wptr[PTR_W] != r_rptr[PTR_W]) &&
                   (r_wptr[PTR_W-1:0] == r_rptr[PTR_W-1:0]);
  assign w_level = r_wptr - r_rptr;

  assign w_tick    = (r_cnt == '0);
  // pop decision uses pre-push state: a push on an empty-FIFO tick is not seen
  assign w_pop     = w_tick & ~w_empty;
  // a simultaneous pop frees the slot, so a full FIFO still accepts the push
  assign w_push_ok = w_push & (~w_full | w_pop);

  always_comb begin
    w_lvl_sat = 3'(w_level);
    if (int'(w_level) > 7) w_lvl_sat = 3'd7;
  end

  assign w_status = {r_ovf, r_und, r_armed, 2'b00, w_lvl_sat};

  always_ff @(posedge i_clk or negedge i_rst_b) begin
    if (!i_rst_b) begin
      r_sck_m <= 1'b0; r_sck_s <= 1'b0; r_sck_d <= 1'b0;
      r_cs_m  <= 1'b1; r_cs_s  <= 1'b1; r_cs_d  <= 1'b1;
      r_mosi_m <= 1'b0; r_mosi_s <= 1'b0;
    end else begin
      r_sck_m <= i_spi_sck;   r_sck_s <= r_sck_m;   r_sck_d <= r_sck_s;
      r_cs_m  <= i_spi_cs_b;  r_cs_s  <= r_cs_m;    r_cs_d  <= r_cs_s;
      r_mosi_m <= i_spi_mosi; r_mosi_s <= r_mosi_m;
    end
  end

  // receive shifter and MISO shifter
  always_ff @(posedge i_clk or negedge i_rst_b) begin
    if (!i_rst_b) begin
      r_shift  <= 8'h00;
      r_bitcnt <= 3'd0;
      r_tx     <= 8'h00;
    end else begin
      if (r_cs_s) begin
        r_bitcnt <= 3'd0;
      end else if (w_sck_rise) begin
        r_shift  <= w_byte;
        r_bitcnt <= r_bitcnt + 3'd1;
      end
      if (w_cs_fall || w_push) r_tx <= w_status;
      else if (w_sck_fall)     r_tx <= {r_tx[6:0], 1'b0};
    end
  end

  always_ff @(posedge i_clk) begin
    if (w_push_ok) r_mem[r_wptr[PTR_W-1:0]] <= w_byte;
  end

  // FIFO pointers, pacer, output register and sticky flags
  always_ff @(posedge i_clk or negedge i_rst_b) begin
    if (!i_rst_b) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_cnt   <= '0;
      r_dout  <= 8'h80;
      r_dv    <= 1'b0;
      r_armed <= 1'b0;
      r_und   <= 1'b0;
      r_ovf   <= 1'b0;
    end else begin
      if (w_push_ok) r_wptr <= r_wptr + PTR_ONE;
      if (w_pop)     r_rptr <= r_rptr + PTR_ONE;
      r_cnt <= w_tick ? i_div : r_cnt - CNT_ONE;
      r_dv  <= w_pop;
      if (w_pop) r_dout <= r_mem[r_rptr[PTR_W-1:0]];
      // set events override a same-cycle clear
      r_armed <= (r_armed & ~i_clr_flags) | w_pop;
      r_und   <= (r_und & ~i_clr_flags) | (w_tick & w_empty & r_armed);
      r_ovf   <= (r_ovf & ~i_clr_flags) | (w_push & w_full & ~w_pop);
    end
  end

  assign o_spi_miso  = ~r_cs_s & r_tx[7];
  assign o_d_out     = r_dout;
  assign o_d_valid   = r_dv;
  assign o_underflow = r_und;
  assign o_overflow  = r_ovf;

endmodule

// File: tb/tb_ef_smsdac_spi_rx.sv
// Bench for ef_smsdac_spi_rx: queue-based behavioural model checked every
// cycle, directed scenarios with literal expectations, then a random tail.
module tb_ef_smsdac_spi_rx;
  localparam int DEPTH = 4;

  logic       clk = 1'b0, rst_b, sck, cs_b, mosi, miso, clr, dv, und, ovf;
  logic [7:0] div, dout;

  ef_smsdac_spi_rx #(.FIFO_DEPTH(DEPTH), .DIV_W(8)) dut (
    .i_clk(clk), .i_rst_b(rst_b), .i_spi_sck(sck), .i_spi_cs_b(cs_b),
    .i_spi_mosi(mosi), .o_spi_miso(miso), .i_div(div), .i_clr_flags(clr),
    .o_d_out(dout), .o_d_valid(dv), .o_underflow(und), .o_overflow(ovf));

  always #5 clk = ~clk;

  int n_chk = 0, n_fail = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  int         edge_cnt = 0;
  int         pend_edge[$];
  logic [7:0] pend_byte[$];
  int         csf_edge = -1;
  logic [7:0] m_q[$];
  logic [7:0] m_dout, m_status, m_pb;
  logic       m_dv, m_arm, m_und, m_ovf, m_tick, m_psh, m_pop, s_arm, s_und, s_ovf;
  int         m_cnt, m_sz;

  always @(posedge clk) begin
    edge_cnt++;
    if (!rst_b) begin
      m_q.delete(); m_dout = 8'h80; m_dv = 0; m_arm = 0; m_und = 0; m_ovf = 0; m_cnt = 0;
    end else begin
      m_tick = (m_cnt == 0);
      m_psh = 0;
      if (pend_edge.size() > 0 && pend_edge[0] == edge_cnt) begin
        m_psh = 1; m_pb = pend_byte.pop_front(); void'(pend_edge.pop_front());
      end
      if (csf_edge == edge_cnt) begin
        m_sz = (m_q.size() > 7) ? 7 : m_q.size();
        m_status = {m_ovf, m_und, m_arm, 2'b00, 3'(m_sz)};
      end
      m_pop = m_tick && (m_q.size() > 0);
      s_arm = m_pop;
      s_und = m_tick && (m_q.size() == 0) && m_arm;
      s_ovf = 0;
      if (m_pop) m_dout = m_q.pop_front();
      m_dv = m_pop;
      if (m_psh) begin
        if (m_q.size() < DEPTH) m_q.push_back(m_pb); else s_ovf = 1;
      end
      if (clr) begin m_arm = 0; m_und = 0; m_ovf = 0; end
      m_arm |= s_arm; m_und |= s_und; m_ovf |= s_ovf;
      m_cnt = m_tick ? int'(div) : m_cnt - 1;
    end
  end

  // ---------------- compare process ----------------
  logic [7:0] pops[$];
  always @(posedge clk) begin
    #1;
    if (rst_b) begin
      chk("d_out", dout, m_dout);
      chk("d_valid", dv, m_dv);
      chk("underflow", und, m_und);
      chk("overflow", ovf, m_ovf);
      if (dv) pops.push_back(dout);
    end
  end

  // ---------------- SPI host ----------------
  logic [7:0] tx_b[8];

  task automatic spi_frame(input int n, output logic [7:0] st);
    st = 8'h00;
    cs_b = 0; mosi = tx_b[0][7]; csf_edge = edge_cnt + 3;
    repeat (4) @(negedge clk);
    for (int k = 0; k < n; k++) begin
      for (int b = 7; b >= 0; b--) begin
        if (k == 0) st = {st[6:0], miso};
        sck = 1;
        if (b == 0) begin pend_edge.push_back(edge_cnt + 3); pend_byte.push_back(tx_b[k]); end
        repeat (3) @(negedge clk);
        sck = 0;
        if (b > 0) mosi = tx_b[k][b-1];
        else if (k + 1 < n) mosi = tx_b[k+1][7];
        repeat (3) @(negedge clk);
      end
    end
    cs_b = 1;
    repeat (6) @(negedge clk);
  endtask

  task automatic spi_partial(input int nbits, input bit keep_cs);
    cs_b = 0; mosi = 1'($urandom);
    repeat (4) @(negedge clk);
    for (int b = 0; b < nbits; b++) begin
      sck = 1; repeat (3) @(negedge clk);
      sck = 0; mosi = 1'($urandom); repeat (3) @(negedge clk);
    end
    if (!keep_cs) begin cs_b = 1; repeat (6) @(negedge clk); end
  endtask

  task automatic pulse_clr();
    clr = 1; @(negedge clk); clr = 0; @(negedge clk);
  endtask

  task automatic wait_cnt(input int tgt);
    int g = 0;
    while (m_cnt != tgt && g < 3000) begin @(negedge clk); g++; end
    chk("pacer_wait", (m_cnt == tgt), 1);
  endtask

  task automatic wait_pops(input int n, input int budget);
    int g = 0;
    while (pops.size() < n && g < budget) begin @(negedge clk); g++; end
    chk("pop_wait", (pops.size() >= n), 1);
  endtask

  task automatic reset_checks(input string tag);
    chk({tag, "_dout"}, dout, 8'h80);
    chk({tag, "_dvalid"}, dv, 0);
    chk({tag, "_und"}, und, 0);
    chk({tag, "_ovf"}, ovf, 0);
    chk({tag, "_miso"}, miso, 0);
  endtask

  logic [7:0] st;
  int cnt_dv, run, max_run;
  logic [7:0] exp6[6] = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h77, 8'h78};
  logic [7:0] exp4[4] = '{8'h12, 8'h13, 8'h14, 8'h15};

  initial begin
    rst_b = 0; sck = 0; cs_b = 1; mosi = 0; div = 8'd9; clr = 0;
    repeat (3) @(negedge clk);
    reset_checks("rst0");
    rst_b = 1; repeat (5) @(negedge clk);

    // reset mid-frame, then a clean frame
    spi_partial(3, 1);
    rst_b = 0; cs_b = 1; sck = 0;
    repeat (3) @(negedge clk);
    reset_checks("rst_mid");
    rst_b = 1; repeat (4) @(negedge clk);
    pops.delete();
    tx_b[0] = 8'h5A; spi_frame(1, st);
    wait_pops(1, 200);
    chk("rst_frame_byte", pops[0], 8'h5A);

    // single byte, div=9
    pulse_clr(); pops.delete();
    tx_b[0] = 8'hA5; spi_frame(1, st);
    wait_pops(1, 200);
    chk("single_byte", pops[0], 8'hA5);
    repeat (25) @(negedge clk);
    chk("single_pulse", pops.size(), 1);
    chk("single_hold", dout, 8'hA5);
    chk("single_underflow", und, 1);

    // burst of 6 into depth 4, div=255; first push lands on a tick
    div = 8'd255; pulse_clr();
    wait_cnt(48);
    pops.delete();
    for (int i = 0; i < 6; i++) tx_b[i] = 8'(i + 1);
    spi_frame(6, st);
    wait_pops(2, 700);
    chk("burst_overflow", ovf, 1);
    tx_b[0] = 8'h77; spi_frame(1, st);
    chk("miso_status_lit", st, 8'hA2);
    chk("miso_status_model", st, m_status);
    pulse_clr();
    tx_b[0] = 8'h78; spi_frame(1, st);
    chk("miso_after_clr", st, m_status);
    chk("miso_after_clr_flags", st[7:5], 3'b000);
    wait_pops(6, 1400);
    for (int i = 0; i < 6; i++) chk($sformatf("burst_seq%0d", i), pops[i], exp6[i]);

    // push landing on a full-FIFO pop cycle
    pulse_clr();
    wait_cnt(240);
    for (int i = 0; i < 5; i++) tx_b[i] = 8'(8'h11 + i);
    spi_frame(5, st);
    chk("full_pop_push_ovf", ovf, 0);

    // div=0 drains the full FIFO one entry per cycle
    pops.delete(); div = 8'd0;
    cnt_dv = 0; run = 0; max_run = 0;
    repeat (300) begin
      @(negedge clk);
      if (dv) begin cnt_dv++; run++; if (run > max_run) max_run = run; end else run = 0;
    end
    chk("drain_dvalid_cycles", cnt_dv, 4);
    chk("drain_consecutive", max_run, 4);
    for (int i = 0; i < 4; i++) chk($sformatf("drain_seq%0d", i), (pops.size() > i) ? pops[i] : 8'hxx, exp4[i]);

    // aborted byte then a full one
    div = 8'd255; repeat (3) @(negedge clk);
    pulse_clr();
    wait_cnt(250);
    pops.delete();
    spi_partial(5, 0);
    tx_b[0] = 8'h3C; spi_frame(1, st);
    tx_b[0] = 8'h99; spi_frame(1, st);
    chk("abort_status_lit", st, 8'h01);
    chk("abort_status_model", st, m_status);
    wait_pops(1, 400);
    chk("abort_byte", pops[0], 8'h3C);

    // randomized tail
    for (int it = 0; it < 8; it++) begin
      int nb;
      div = 8'($urandom_range(0, 40));
      nb = $urandom_range(1, 4);
      for (int i = 0; i < nb; i++) tx_b[i] = 8'($urandom);
      if ($urandom_range(0, 2) == 0) pulse_clr();
      spi_frame(nb, st);
      chk($sformatf("rand_status%0d", it), st, m_status);
      repeat ($urandom_range(0, 60)) @(negedge clk);
    end
    repeat (200) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
